// File: rtl/uart_tx_type_arbiter.sv
// Round-robin arbiter that frames one source's payload as HEAD, TYPE, LEN, payload, CHK
// and streams the bytes to a UART transmitter over a valid/ready handshake.
module uart_tx_type_arbiter #(
    parameter int         P_CH_NUM = 4,
    parameter logic [7:0] P_HEAD   = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [P_CH_NUM-1:0]   i_req,
    input  logic [P_CH_NUM*8-1:0] i_len,
    output logic [P_CH_NUM-1:0]   o_grant,
    input  logic [7:0]            i_src_data,
    output logic                  o_src_rd,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy
);
    localparam int IDX_W = (P_CH_NUM > 1) ? $clog2(P_CH_NUM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_TYPE, S_LEN, S_DATA, S_CHK} state_t;

    state_t              r_state, w_next;
    logic [P_CH_NUM-1:0] r_grant;
    logic [IDX_W-1:0]    r_ptr, r_idx, w_sel;
    logic [7:0]          r_len, r_chk, r_cnt, w_type, w_sel_len;
    logic                w_found, w_xfer;

    // First requester at or after the pointer, searching upward with wrap
    always_comb begin : rr_search
        int k;
        k       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < P_CH_NUM; i++) begin
            k = (int'(r_ptr) + i) % P_CH_NUM;
            if (!w_found && i_req[IDX_W'(k)]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(k);
            end
        end
    end

    assign w_sel_len  = i_len[8*w_sel +: 8];
    assign w_type     = 8'(r_idx);
    assign o_tx_valid = (r_state != S_IDLE);
    assign o_busy     = (r_state != S_IDLE);
    assign w_xfer     = o_tx_valid & i_tx_ready;
    assign o_src_rd   = (r_state == S_DATA) & i_tx_ready;
    assign o_grant    = r_grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_tx_data = 8'h00;
        unique case (r_state)
            S_IDLE: if (w_found) w_next = S_HEAD;
            S_HEAD: begin
                o_tx_data = P_HEAD;
                if (w_xfer) w_next = S_TYPE;
            end
            S_TYPE: begin
                o_tx_data = w_type;
                if (w_xfer) w_next = S_LEN;
            end
            S_LEN: begin
                o_tx_data = r_len;
                if (w_xfer) w_next = (r_len != 8'd0) ? S_DATA : S_CHK;
            end
            S_DATA: begin
                o_tx_data = i_src_data;
                if (w_xfer && (r_cnt == r_len - 8'd1)) w_next = S_CHK;
            end
            S_CHK: begin
                o_tx_data = r_chk;
                if (w_xfer) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, latched channel/length, running checksum and payload counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_len   <= 8'd0;
            r_chk   <= 8'd0;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= P_CH_NUM'(1) << w_sel;
                        r_idx   <= w_sel;
                        r_len   <= w_sel_len;
                        r_chk   <= 8'd0;
                        r_cnt   <= 8'd0;
                    end
                end
                S_TYPE: if (w_xfer) r_chk <= r_chk + w_type;
                S_LEN:  if (w_xfer) r_chk <= r_chk + r_len;
                S_DATA: begin
                    if (w_xfer) begin
                        r_chk <= r_chk + i_src_data;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_grant <= '0;
                        r_ptr   <= (r_idx == IDX_W'(P_CH_NUM - 1)) ? '0 : r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_type_arbiter.sv
// Scoreboard bench for uart_tx_type_arbiter: expected frame bytes are queued up front
// and checked against every accepted byte on the UART side.
module tb_uart_tx_type_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] len = '0;
    logic [N-1:0]   grant;
    logic [7:0]     src_data;
    logic           src_rd;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic           busy;

    uart_tx_type_arbiter #(.P_CH_NUM(N), .P_HEAD(8'hA5)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_len(len), .o_grant(grant),
        .i_src_data(src_data), .o_src_rd(src_rd), .o_tx_data(tx_data),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]   data;
        logic [N-1:0] grant;
        logic         rd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] src_mem [N][64];
    int         src_rp [N] = '{default: 0};
    int         n_assert = 0;
    int         n_fail = 0;
    int         rdy_mode = 0;
    int         rdy_phase = 0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;

    // FWFT source model: head of the granted channel's FIFO
    always_comb begin
        src_data = 8'h00;
        for (int k = 0; k < N; k++)
            if (grant[k]) src_data = src_mem[k][src_rp[k]];
    end

    always @(posedge clk)
        for (int k = 0; k < N; k++)
            if (grant[k] && src_rd) src_rp[k] <= src_rp[k] + 1;

    // Ready pattern 1,0,0,1 when throttled
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) tx_ready = 1'b1;
        else begin
            tx_ready  = (rdy_phase == 0) || (rdy_phase == 3);
            rdy_phase = (rdy_phase + 1) % 4;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) stall_pend = 1'b0;
        else begin
            if (tx_valid && tx_ready) begin
                n_assert++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got data %02h grant %b, required no transfer", tx_data, grant);
                end else begin
                    e = sb.pop_front();
                    if ({tx_data, grant, src_rd} !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got data %02h grant %b rd %b, required data %02h grant %b rd %b",
                                 tx_data, grant, src_rd, e.data, e.grant, e.rd);
                    end
                end
            end
            if (stall_pend && tx_valid) begin
                n_assert++;
                if (tx_data !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %02h, required %02h", tx_data, stall_data);
                end
            end
            if (src_rd) begin
                n_assert++;
                if (!(tx_valid && tx_ready)) begin
                    n_fail++;
                    $display("FAIL src_rd_no_xfer: got rd 1 with valid %b ready %b, required valid 1 ready 1", tx_valid, tx_ready);
                end
            end
            stall_pend = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic push_byte(input logic [7:0] d, input int ch, input logic rd);
        logic [N-1:0] g;
        g = '0;
        g[ch] = 1'b1;
        sb.push_back({d, g, rd});
    endtask

    // Reference frame: checksum over TYPE, LEN and payload, modulo 256
    task automatic push_frame(input int ch, input int ln, input int off);
        logic [7:0] chk, b;
        chk = 8'(ch) + 8'(ln);
        push_byte(8'hA5, ch, 1'b0);
        push_byte(8'(ch), ch, 1'b0);
        push_byte(8'(ln), ch, 1'b0);
        for (int i = 0; i < ln; i++) begin
            b = src_mem[ch][src_rp[ch] + off + i];
            chk = chk + b;
            push_byte(b, ch, 1'b1);
        end
        push_byte(chk, ch, 1'b0);
    endtask

    task automatic run_frame(input int ch, output int gcyc, output int rds);
        int  t;
        bit  granted;
        granted = 0;
        gcyc = 0;
        rds = 0;
        req[ch] = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (grant[ch]) begin
                granted = 1;
                req[ch] = 1'b0;
                gcyc++;
            end
            if (src_rd) rds++;
            if (granted && !busy && sb.size() == 0) break;
        end
        n_assert++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL frame_timeout ch%0d: got %0d bytes pending, required 0", ch, sb.size());
            sb.delete();
            req[ch] = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2;
        n_assert++;
        if ({grant, tx_valid, tx_data, src_rd, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant %b valid %b data %02h rd %b busy %b, required all 0",
                     grant, tx_valid, tx_data, src_rd, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got busy %b, required 0", busy);
        end
    endtask

    task automatic test_round_robin;
        int frames, idle, t;
        logic prev_busy;
        len = 32'h01010101;
        for (int k = 0; k < N; k++) src_mem[k][src_rp[k]] = 8'(8'h10 * (k + 1) + 3);
        src_mem[0][src_rp[0] + 1] = 8'h5E;
        push_frame(0, 1, 0);
        push_frame(1, 1, 0);
        push_frame(2, 1, 0);
        push_frame(3, 1, 0);
        push_frame(0, 1, 1);
        frames = 0;
        idle = 0;
        prev_busy = 1'b0;
        req = 4'b1111;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                frames++;
                if (frames == 5) req = '0;
            end
            if (!busy && frames >= 1 && frames < 5) idle++;
            prev_busy = busy;
            if (frames == 5 && !busy) break;
        end
        req = '0;
        n_assert++;
        if (frames != 5 || t >= 300) begin
            n_fail++;
            $display("FAIL rr_frames: got %0d frames, required 5", frames);
        end
        n_assert++;
        if (idle != 4) begin
            n_fail++;
            $display("FAIL rr_gap: got %0d idle cycles, required 4", idle);
        end
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d bytes pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_single_frame;
        int g, r;
        len = '0;
        len[23:16] = 8'd2;
        src_mem[2][src_rp[2]]     = 8'h11;
        src_mem[2][src_rp[2] + 1] = 8'h22;
        push_byte(8'hA5, 2, 1'b0);
        push_byte(8'h02, 2, 1'b0);
        push_byte(8'h02, 2, 1'b0);
        push_byte(8'h11, 2, 1'b1);
        push_byte(8'h22, 2, 1'b1);
        push_byte(8'h37, 2, 1'b0);
        run_frame(2, g, r);
        n_assert++;
        if (g != 6) begin
            n_fail++;
            $display("FAIL single_grant_cycles: got %0d, required 6", g);
        end
        n_assert++;
        if (r != 2) begin
            n_fail++;
            $display("FAIL single_rd_pulses: got %0d, required 2", r);
        end
    endtask

    task automatic test_backpressure;
        int g, r;
        len = '0;
        len[15:8] = 8'd3;
        src_mem[1][src_rp[1]]     = 8'h5A;
        src_mem[1][src_rp[1] + 1] = 8'h6B;
        src_mem[1][src_rp[1] + 2] = 8'h7C;
        push_frame(1, 3, 0);
        rdy_mode = 1;
        run_frame(1, g, r);
        rdy_mode = 0;
        n_assert++;
        if (r != 3) begin
            n_fail++;
            $display("FAIL bp_rd_pulses: got %0d, required 3", r);
        end
        n_assert++;
        if (g <= 7) begin
            n_fail++;
            $display("FAIL bp_stalled: got %0d grant cycles, required more than 7", g);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_checksum_wrap;
        int g, r;
        len = '0;
        len[15:8] = 8'd3;
        for (int i = 0; i < 3; i++) src_mem[1][src_rp[1] + i] = 8'hFF;
        push_byte(8'hA5, 1, 1'b0);
        push_byte(8'h01, 1, 1'b0);
        push_byte(8'h03, 1, 1'b0);
        for (int i = 0; i < 3; i++) push_byte(8'hFF, 1, 1'b1);
        push_byte(8'h01, 1, 1'b0);
        run_frame(1, g, r);
        n_assert++;
        if (r != 3) begin
            n_fail++;
            $display("FAIL wrap_rd_pulses: got %0d, required 3", r);
        end
    endtask

    task automatic test_zero_length;
        int g, r;
        len = '0;
        push_byte(8'hA5, 3, 1'b0);
        push_byte(8'h03, 3, 1'b0);
        push_byte(8'h00, 3, 1'b0);
        push_byte(8'h03, 3, 1'b0);
        run_frame(3, g, r);
        n_assert++;
        if (r != 0) begin
            n_fail++;
            $display("FAIL zero_rd_pulses: got %0d, required 0", r);
        end
        n_assert++;
        if (g != 4) begin
            n_fail++;
            $display("FAIL zero_grant_cycles: got %0d, required 4", g);
        end
    endtask

    task automatic test_reset_mid_data;
        int g, r, t;
        len = '0;
        push_frame(2, 0, 0);
        run_frame(2, g, r);
        len[15:8] = 8'd3;
        src_mem[1][src_rp[1]]     = 8'h31;
        src_mem[1][src_rp[1] + 1] = 8'h32;
        src_mem[1][src_rp[1] + 2] = 8'h33;
        push_byte(8'hA5, 1, 1'b0);
        push_byte(8'h01, 1, 1'b0);
        push_byte(8'h03, 1, 1'b0);
        push_byte(8'h31, 1, 1'b1);
        req[1] = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (grant[1]) req[1] = 1'b0;
            if (src_rd) break;
        end
        req[1] = 1'b0;
        n_assert++;
        if (t >= 50) begin
            n_fail++;
            $display("FAIL rst_setup_timeout: got no payload pop, required one");
        end
        @(posedge clk); #1;
        n_assert++;
        if (tx_data !== 8'h32) begin
            n_fail++;
            $display("FAIL rst_second_byte: got %02h, required 32", tx_data);
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if ({grant, tx_valid, tx_data, src_rd, busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got grant %b valid %b data %02h rd %b busy %b, required all 0",
                     grant, tx_valid, tx_data, src_rd, busy);
        end
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rst_pending: got %0d bytes pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        len = '0;
        len[7:0]   = 8'd1;
        len[31:24] = 8'd1;
        src_mem[0][src_rp[0]] = 8'h44;
        push_frame(0, 1, 0);
        req[3] = 1'b1;
        run_frame(0, g, r);
        req[3] = 1'b0;
        n_assert++;
        if (g != 5 || r != 1) begin
            n_fail++;
            $display("FAIL rst_ptr_ch0: got %0d grant cycles %0d pops, required 5 and 1", g, r);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 64; i++) src_mem[k][i] = 8'h00;
        test_reset;
        test_round_robin;
        test_single_frame;
        test_backpressure;
        test_checksum_wrap;
        test_zero_length;
        test_reset_mid_data;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_type_arbiter.md
Name: uart_tx_type_arbiter

Overview:
Shares one UART transmit byte channel between P_CH_NUM typed data sources on the bus.
It arbitrates round-robin between requesting sources and wraps each granted source's payload in a fixed frame: HEAD, TYPE, LEN, payload, CHK.
Sources are first-word-fall-through byte FIFOs. The downstream UART TX takes bytes over a valid/ready handshake.

Parameters:
P_CH_NUM, 4, number of requesting sources (2..8); TYPE byte = channel index
P_HEAD, 8'hA5, frame header byte

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset; asynchronous, active-high
i_req  input  P_CH_NUM  per-channel packet request; level, held until granted
i_len  input  P_CH_NUM*8  per-channel payload length; channel k at bits [8k+7:8k]; 0..255
o_grant  output  P_CH_NUM  one-hot grant; held for the whole frame
i_src_data  input  8  payload byte from the granted source (FWFT head), muxed externally by o_grant
o_src_rd  output  1  pop strobe to the granted source, one cycle per accepted payload byte
o_tx_data  output  8  byte to UART TX
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  UART TX can accept a byte
o_busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset values: o_grant=0, o_tx_valid=0, o_tx_data=0, o_src_rd=0, o_busy=0. FSM=IDLE, RR pointer=0, checksum=0, byte counter=0.
- Transfer rule: a byte transfers on a rising edge where o_tx_valid=1 and i_tx_ready=1. While o_tx_valid=1 and i_tx_ready=0, o_tx_data holds stable.
- FSM states: IDLE, HEAD, TYPE, LEN, DATA, CHK.
- IDLE: if any i_req bit is set, the next edge does the following:
  - Selects the first requesting channel at or after the RR pointer, searching upward with wrap.
  - Sets o_grant.
  - Latches that channel's index and i_len.
  - Clears the checksum.
  - Goes to HEAD with o_tx_valid=1.
  - Latency: request sampled at edge N -> grant and HEAD valid after edge N.
- HEAD: o_tx_data=P_HEAD; on transfer -> TYPE. HEAD is not summed into the checksum.
- TYPE: o_tx_data = channel index (zero-extended); on transfer, checksum += index, -> LEN.
- LEN: o_tx_data = latched length; on transfer, checksum += length. Then -> DATA if length != 0, else -> CHK.
- DATA:
  - o_tx_data = i_src_data (combinational pass-through).
  - o_src_rd = o_tx_valid & i_tx_ready.
  - On each transfer: checksum += byte, counter += 1.
  - When the transfer with counter = length-1 completes -> CHK.
- CHK: o_tx_data = checksum; on transfer -> IDLE. On the same edge: o_grant=0, o_tx_valid=0, RR pointer = granted index + 1 mod P_CH_NUM.
- Arithmetic: checksum is an 8-bit sum modulo 256 over TYPE, LEN and payload bytes. The byte counter is 8 bits.
- Minimum inter-frame gap is one IDLE cycle, so back-to-back frames are possible.
- o_src_rd only pulses in DATA and only on a transfer. The number of pulses per frame equals the latched length exactly.
- i_req deasserted mid-frame: ignored; the frame completes.
- i_len changing mid-frame: ignored; the latched value is used.
- Request from a non-granted channel mid-frame: waits; it is considered at the next IDLE.
- Reset mid-frame: the frame is abandoned immediately and all state returns to reset values. The source keeps its unread bytes.
- Length 0: frame is HEAD, TYPE, 00, CHK(=TYPE); no o_src_rd pulses.

Test Plan:
- Single frame: ch2 requests, len=2, source bytes 11,22, i_tx_ready=1 -> o_tx_data sequence A5,02,02,11,22,37. o_grant=4'b0100 for 6 cycles; 2 o_src_rd pulses.
- Round robin: i_req=4'b1111 held, all len=1 -> grants in order ch0,ch1,ch2,ch3,ch0, each a complete 5-byte frame with a 1-cycle IDLE gap.
- Backpressure: ch1 len=3, i_tx_ready toggled 1,0,0,1 pattern -> o_tx_data stable while stalled, no duplicated or dropped bytes, exactly 3 o_src_rd pulses.
- Checksum wrap: ch1 len=3, bytes FF,FF,FF -> CHK = (01+03+2FD) mod 256 = 01.
- Zero length: ch3 len=0 -> A5,03,00,03; o_src_rd never asserted.
- Reset mid-DATA: assert i_rst during the 2nd payload byte -> outputs 0 in the same cycle (async). After release, an ch0 request is granted first (pointer reset) and the frame restarts from A5.
